// File: rtl/mux_scan_nch.sv
// N-channel registered selector: manual channel select, or auto-scan over the
// enabled channels with a fixed dwell per channel. All outputs are registered.
module mux_scan_nch #(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  parameter  int SCAN_DIV = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       en_mask,
  output logic [WIDTH-1:0]          dout,
  output logic [SEL_W-1:0]          ch,
  output logic [CHANNELS-1:0]       ch_onehot,
  output logic                      valid
);

  localparam int DCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CHANNELS-1:0][WIDTH-1:0] din_a;
  logic [DCNT_W-1:0]              dcnt, dcnt_n;
  logic [SEL_W-1:0]               ch_n, nxt;
  logic [WIDTH-1:0]               dout_n;
  logic [CHANNELS-1:0]            onehot_n;
  logic                           vld_n, found;
  int                             idx;

  assign din_a = din;

  // First enabled channel after ch, wrapping; i == CHANNELS lands back on ch
  // so a lone enabled channel re-selects itself.
  always_comb begin
    nxt   = ch;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = (int'(ch) + i) % CHANNELS;
      if (!found && en_mask[idx]) begin
        nxt   = SEL_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ch_n   = ch;
    dcnt_n = dcnt;
    vld_n  = 1'b0;
    dout_n = '0;
    if (!mode) begin
      dcnt_n = '0;
      if (int'(sel) < CHANNELS) begin
        ch_n   = sel;
        vld_n  = 1'b1;
        dout_n = din_a[sel];
      end
    end else if (en_mask != '0) begin
      vld_n = 1'b1;
      // A disabled current channel ends its dwell right away.
      if (!en_mask[ch] || dcnt == DCNT_W'(SCAN_DIV - 1)) begin
        ch_n   = nxt;
        dcnt_n = '0;
      end else begin
        dcnt_n = dcnt + 1'b1;
      end
      dout_n = din_a[ch_n];
    end
    onehot_n = vld_n ? (CHANNELS'(1) << ch_n) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch        <= '0;
      dcnt      <= '0;
      dout      <= '0;
      ch_onehot <= '0;
      valid     <= 1'b0;
    end else begin
      ch        <= ch_n;
      dcnt      <= dcnt_n;
      dout      <= dout_n;
      ch_onehot <= onehot_n;
      valid     <= vld_n;
    end
  end

endmodule

// File: tb/tb_mux_scan_nch.sv
// Directed bench for mux_scan_nch: manual select, full/masked/empty scan,
// mid-dwell disable, and asynchronous reset in the middle of a dwell.
module tb_mux_scan_nch;
  localparam int WIDTH    = 4;
  localparam int CHANNELS = 4;
  localparam int SCAN_DIV = 3;
  localparam int SEL_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [CHANNELS*WIDTH-1:0] din;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS-1:0]       en_mask;
  logic [WIDTH-1:0]          dout;
  logic [SEL_W-1:0]          ch;
  logic [CHANNELS-1:0]       ch_onehot;
  logic                      valid;

  int n_chk = 0;
  int n_err = 0;

  mux_scan_nch #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .sel(sel),
    .en_mask(en_mask), .dout(dout), .ch(ch), .ch_onehot(ch_onehot), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for channel c being selected (v=1) or nothing legal (v=0).
  task automatic check_state(input string tag, input int c, input logic v);
    logic [WIDTH-1:0]    e_dout;
    logic [CHANNELS-1:0] e_oh;
    e_dout = v ? din[c*WIDTH +: WIDTH] : '0;
    e_oh   = v ? (CHANNELS'(1) << c) : '0;
    chk({tag, ".ch"},     32'(ch),        32'(c));
    chk({tag, ".dout"},   32'(dout),      32'(e_dout));
    chk({tag, ".onehot"}, 32'(ch_onehot), 32'(e_oh));
    chk({tag, ".valid"},  32'(valid),     32'(v));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input string tag, input int exp_q[$]);
    foreach (exp_q[i]) begin
      step();
      check_state($sformatf("%s[%0d]", tag, i), exp_q[i], 1'b1);
    end
  endtask

  initial begin
    rst_n   = 1'b1;
    din     = 16'b1001_0011_1100_0101;
    mode    = 1'b0;
    sel     = '0;
    en_mask = '0;

    // Reset asserted between edges must clear outputs without a clock.
    #2 rst_n = 1'b0;
    #1 check_state("rst_async", 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Manual select, each sel held for two edges.
    for (int s = 0; s < CHANNELS; s++) begin
      sel = SEL_W'(s);
      step(); check_state($sformatf("man%0d_a", s), s, 1'b1);
      step(); check_state($sformatf("man%0d_b", s), s, 1'b1);
    end

    // Live data tracking in manual mode.
    din[15:12] = 4'b0110;
    step(); check_state("man_track", 3, 1'b1);
    din[15:12] = 4'b1001;

    // Full scan from ch=0; the manual cycle at ch=0 is the dcnt=0 slot.
    sel = '0;
    step(); check_state("scan_start", 0, 1'b1);
    mode = 1'b1; en_mask = 4'b1111;
    run_seq("full", '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0});

    // ch=0 just entered; masking it off advances straight to ch1.
    en_mask = 4'b1010;
    run_seq("mask1010", '{1, 1, 1, 3, 3, 3, 1, 1, 1, 3, 3, 3});

    en_mask = 4'b0000;
    step(); check_state("empty_a", 3, 1'b0);
    step(); check_state("empty_b", 3, 1'b0);

    // Park on ch2 (dcnt=0), then drop ch2 from the mask.
    mode = 1'b0; sel = 2'd2;
    step(); check_state("park2", 2, 1'b1);
    mode = 1'b1; en_mask = 4'b1011;
    run_seq("middis", '{3, 3, 3, 0});

    // Reset in the middle of a ch2 dwell (dcnt=1).
    mode = 1'b0; sel = 2'd2;
    step(); check_state("park2b", 2, 1'b1);
    mode = 1'b1; en_mask = 4'b1111;
    step(); check_state("dwell2", 2, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_state("rst_mid", 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_seq("restart", '{0, 0, 1, 1, 1, 2});

    // Back to manual: sel takes effect on the next edge.
    mode = 1'b0; sel = 2'd3;
    step(); check_state("to_man", 3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #20000;
    n_err++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
